// File: rtl/game_state_if.sv
// Signal bundle between the game-state controller and the rest of the game:
// cursor, character and combat status in, screen state and control strobes out.
interface game_state_if;
   logic [11:0] mouse_x;
   logic [11:0] mouse_y;
   logic        mouse_left;
   logic [1:0]  char_class;
   logic [3:0]  player_hp;
   logic        boss_dead;
   logic        vblnk;
   logic        pause_key;
   logic [1:0]  game_active;
   logic        paused;
   logic        game_reset;
   logic        start_hover;

   modport master (
      output mouse_x, mouse_y, mouse_left, char_class, player_hp, boss_dead,
             vblnk, pause_key,
      input  game_active, paused, game_reset, start_hover
   );

   modport slave (
      input  mouse_x, mouse_y, mouse_left, char_class, player_hp, boss_dead,
             vblnk, pause_key,
      output game_active, paused, game_reset, start_hover
   );
endinterface

// File: rtl/game_state_ctrl.sv
// Top-level game screen sequencer: menu -> play -> lose/win -> menu.
// Optional pause support is compiled in with macro GAME_PAUSE_EN.
//
// state  | meaning
// S_MENU | title screen, waiting for a start click with a class chosen
// S_PLAY | game running
// S_LOSE | game-over screen held for END_FRAMES frames or until a click
// S_WIN  | win screen held for END_FRAMES frames or until a click
module game_state_ctrl #(
   parameter int unsigned START_X    = 472,
   parameter int unsigned START_Y    = 300,
   parameter int unsigned START_W    = 80,
   parameter int unsigned START_H    = 32,
   parameter int unsigned END_FRAMES = 180
) (
   input  logic         clk,
   input  logic         rst,
   game_state_if.slave  bus
);

   typedef enum logic [1:0] {
      S_MENU = 2'd0,
      S_PLAY = 2'd1,
      S_LOSE = 2'd2,
      S_WIN  = 2'd3
   } state_t;

   localparam int unsigned CNT_W = (END_FRAMES > 255) ? $clog2(END_FRAMES + 1) : 8;
   localparam logic [11:0] X_LO = 12'(START_X);
   localparam logic [11:0] X_HI = 12'(START_X + START_W);
   localparam logic [11:0] Y_LO = 12'(START_Y);
   localparam logic [11:0] Y_HI = 12'(START_Y + START_H);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               arm_q;
   logic               mouse_left_q;
   logic               vblnk_q;
   logic               game_reset_q, game_reset_d;
   logic               start_hover_q, start_hover_d;
   logic               click;
   logic               frame_tick;
   logic               in_region;
   logic               hold_play;

   // arm_q masks edges on the first cycle after reset so a button held
   // through reset release is captured as a level, not seen as a click.
   assign click      = arm_q & bus.mouse_left & ~mouse_left_q;
   assign frame_tick = arm_q & bus.vblnk & ~vblnk_q;
   assign in_region  = (bus.mouse_x >= X_LO) && (bus.mouse_x < X_HI) &&
                       (bus.mouse_y >= Y_LO) && (bus.mouse_y < Y_HI);

`ifdef GAME_PAUSE_EN
   logic pause_key_q;
   logic paused_q, paused_d;
   logic pause_edge;

   assign pause_edge = arm_q & bus.pause_key & ~pause_key_q;
   assign hold_play  = paused_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pause_key_q <= 1'b0;
         paused_q    <= 1'b0;
      end else begin
         pause_key_q <= bus.pause_key;
         paused_q    <= paused_d;
      end
   end

   always_comb begin
      paused_d = 1'b0;
      if (state_q == S_PLAY && state_d == S_PLAY)
         paused_d = paused_q ^ pause_edge;
   end

   assign bus.paused = paused_q;
`else
   wire unused_pause_key = bus.pause_key;

   assign hold_play  = 1'b0;
   assign bus.paused = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_MENU;
         cnt_q         <= '0;
         arm_q         <= 1'b0;
         mouse_left_q  <= 1'b0;
         vblnk_q       <= 1'b0;
         game_reset_q  <= 1'b0;
         start_hover_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         arm_q         <= 1'b1;
         mouse_left_q  <= bus.mouse_left;
         vblnk_q       <= bus.vblnk;
         game_reset_q  <= game_reset_d;
         start_hover_q <= start_hover_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_MENU: begin
            if (click && in_region && bus.char_class != 2'd0)
               state_d = S_PLAY;
         end
         S_PLAY: begin
            // LOSE is checked first so a simultaneous death and boss kill loses.
            if (!hold_play && bus.player_hp == 4'd0) begin
               state_d = S_LOSE;
               cnt_d   = CNT_W'(END_FRAMES);
            end else if (!hold_play && bus.boss_dead) begin
               state_d = S_WIN;
               cnt_d   = CNT_W'(END_FRAMES);
            end
         end
         default: begin
            // cnt_q <= 1 also covers END_FRAMES == 0: leave on the first tick.
            if (click) begin
               state_d = S_MENU;
               cnt_d   = '0;
            end else if (frame_tick) begin
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = S_MENU;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
      endcase
   end

   always_comb begin
      game_reset_d  = (state_q == S_MENU) && (state_d == S_PLAY);
      start_hover_d = (state_d == S_MENU) && in_region && (bus.char_class != 2'd0);
   end

   assign bus.game_active = state_q;
   assign bus.game_reset  = game_reset_q;
   assign bus.start_hover = start_hover_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: three instances (END_FRAMES 3, default, 0)
// share one stimulus stream; each check targets the instance it concerns.
module tb_game_state_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] mouse_x, mouse_y;
   logic        mouse_left;
   logic [1:0]  char_class;
   logic [3:0]  player_hp;
   logic        boss_dead, vblnk, pause_key;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   game_state_if if_a ();
   game_state_if if_b ();
   game_state_if if_z ();

   assign if_a.mouse_x = mouse_x;       assign if_b.mouse_x = mouse_x;       assign if_z.mouse_x = mouse_x;
   assign if_a.mouse_y = mouse_y;       assign if_b.mouse_y = mouse_y;       assign if_z.mouse_y = mouse_y;
   assign if_a.mouse_left = mouse_left; assign if_b.mouse_left = mouse_left; assign if_z.mouse_left = mouse_left;
   assign if_a.char_class = char_class; assign if_b.char_class = char_class; assign if_z.char_class = char_class;
   assign if_a.player_hp = player_hp;   assign if_b.player_hp = player_hp;   assign if_z.player_hp = player_hp;
   assign if_a.boss_dead = boss_dead;   assign if_b.boss_dead = boss_dead;   assign if_z.boss_dead = boss_dead;
   assign if_a.vblnk = vblnk;           assign if_b.vblnk = vblnk;           assign if_z.vblnk = vblnk;
   assign if_a.pause_key = pause_key;   assign if_b.pause_key = pause_key;   assign if_z.pause_key = pause_key;

   game_state_ctrl #(.END_FRAMES(3)) u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
   game_state_ctrl                   u_dut_b (.clk(clk), .rst(rst), .bus(if_b));
   game_state_ctrl #(.END_FRAMES(0)) u_dut_z (.clk(clk), .rst(rst), .bus(if_z));

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_vblnk();
      vblnk = 1'b1;
      step();
      vblnk = 1'b0;
      step();
   endtask

   // start-region corners: x in [472,552), y in [300,332)
   int hx [6] = '{472, 471, 551, 552, 500, 500};
   int hy [6] = '{300, 300, 331, 310, 332, 299};
   int he [6] = '{1,   0,   1,   0,   0,   0};

   initial begin
      rst = 1'b1;
      mouse_x = 12'd0; mouse_y = 12'd0; mouse_left = 1'b0; char_class = 2'd0;
      player_hp = 4'd5; boss_dead = 1'b0; vblnk = 1'b0; pause_key = 1'b0;
      step();
      step();
      chk("rst_active", int'(if_a.game_active), 0);
      chk("rst_paused", int'(if_a.paused), 0);
      chk("rst_greset", int'(if_a.game_reset), 0);
      chk("rst_hover",  int'(if_a.start_hover), 0);
      rst = 1'b0;
      step();

      // class 0 click is ignored, class 1 click starts play
      mouse_x = 12'd500; mouse_y = 12'd310;
      step();
      chk("hover_cls0", int'(if_a.start_hover), 0);
      mouse_left = 1'b1;
      step();
      chk("click_cls0", int'(if_a.game_active), 0);
      mouse_left = 1'b0;
      char_class = 2'd1;
      step();
      chk("hover_cls1", int'(if_a.start_hover), 1);
      mouse_left = 1'b1;
      step();
      chk("start_play", int'(if_a.game_active), 1);
      chk("greset_hi",  int'(if_a.game_reset), 1);
      chk("hover_play", int'(if_a.start_hover), 0);
      step();
      chk("greset_lo",  int'(if_a.game_reset), 0);

      // death and boss kill together: lose wins; button still held throughout
      player_hp = 4'd0; boss_dead = 1'b1;
      step();
      chk("lose_prio", int'(if_a.game_active), 2);
      pulse_vblnk();
      chk("lose_tick1", int'(if_a.game_active), 2);
      chk("ef0_tick1",  int'(if_z.game_active), 0);
      pulse_vblnk();
      chk("lose_tick2", int'(if_a.game_active), 2);
      vblnk = 1'b1;
      step();
      chk("lose_tick3", int'(if_a.game_active), 0);
      chk("ef180_tick3", int'(if_b.game_active), 2);
      vblnk = 1'b0;
      player_hp = 4'd5; boss_dead = 1'b0;
      step();

      for (int i = 0; i < 6; i++) begin
         mouse_x = 12'(hx[i]); mouse_y = 12'(hy[i]);
         step();
         chk($sformatf("hover_pt%0d", i), int'(if_a.start_hover), he[i]);
      end

      // held button must not return from LOSE until released and pressed again
      mouse_left = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      mouse_x = 12'd500; mouse_y = 12'd310;
      mouse_left = 1'b1;
      step();
      chk("play_again", int'(if_a.game_active), 1);
      player_hp = 4'd0;
      step();
      chk("lose_hp0", int'(if_a.game_active), 2);
      step();
      step();
      chk("held_no_ret", int'(if_a.game_active), 2);
      mouse_left = 1'b0;
      step();
      chk("release_no_ret", int'(if_a.game_active), 2);
      mouse_left = 1'b1;
      step();
      chk("click_ret", int'(if_a.game_active), 0);
      player_hp = 4'd5;
      mouse_left = 1'b0;
      step();
      mouse_left = 1'b1;
      step();
      chk("play_third", int'(if_a.game_active), 1);

`ifdef GAME_PAUSE_EN
      pause_key = 1'b1;
      step();
      chk("pause_on", int'(if_a.paused), 1);
      player_hp = 4'd0;
      step();
      chk("pause_hold", int'(if_a.game_active), 1);
      pause_key = 1'b0;
      step();
      pause_key = 1'b1;
      step();
      chk("pause_off", int'(if_a.paused), 0);
      step();
      chk("unpause_lose", int'(if_a.game_active), 2);
      pause_key = 1'b0;
      player_hp = 4'd5;
      mouse_left = 1'b0;
      step();
      mouse_left = 1'b1;
      step();
      chk("lose_to_menu", int'(if_a.game_active), 0);
      mouse_left = 1'b0;
      step();
      mouse_left = 1'b1;
      step();
      chk("play_fourth", int'(if_a.game_active), 1);
`else
      pause_key = 1'b1;
      step();
      chk("pause_disabled", int'(if_a.paused), 0);
      pause_key = 1'b0;
      step();
`endif

      boss_dead = 1'b1;
      step();
      chk("win", int'(if_a.game_active), 3);
      boss_dead = 1'b0;
      mouse_left = 1'b0;
      step();
      mouse_left = 1'b1;
      step();
      chk("win_click_ret", int'(if_a.game_active), 0);

      // default instance: 80 frames into WIN leaves its counter at 100, then reset
      mouse_left = 1'b0;
      step();
      mouse_left = 1'b1;
      step();
      chk("b_play", int'(if_b.game_active), 1);
      boss_dead = 1'b1;
      step();
      boss_dead = 1'b0;
      mouse_left = 1'b0;
      for (int i = 0; i < 80; i++) pulse_vblnk();
      chk("b_win_cnt100", int'(if_b.game_active), 3);
      #2;
      rst = 1'b1;
      #1;
      chk("async_active", int'(if_b.game_active), 0);
      chk("async_paused", int'(if_b.paused), 0);
      chk("async_greset", int'(if_b.game_reset), 0);
      chk("async_hover",  int'(if_b.start_hover), 0);
      char_class = 2'd2;
      mouse_x = 12'd500; mouse_y = 12'd310;
      mouse_left = 1'b1;
      step();
      rst = 1'b0;
      step();
      chk("held_at_rst1", int'(if_b.game_active), 0);
      step();
      chk("held_at_rst2", int'(if_b.game_active), 0);
      mouse_left = 1'b0;
      step();
      mouse_left = 1'b1;
      step();
      chk("cls2_play",   int'(if_b.game_active), 1);
      chk("cls2_greset", int'(if_b.game_reset), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 Parameter START_X, default 472: left edge of the start-button region in pixels.
REQ-002 Parameter START_Y, default 300: top edge of the start-button region in pixels.
REQ-003 Parameter START_W, default 80: width of the start-button region in pixels.
REQ-004 Parameter START_H, default 32: height of the start-button region in pixels.
REQ-005 Parameter END_FRAMES, default 180: number of frames the game-over or win screen is held.
REQ-006 clk  input  1  system clock, pixel domain.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 mouse_x  input  12  cursor x position.
REQ-009 mouse_y  input  12  cursor y position.
REQ-010 mouse_left  input  1  left button level.
REQ-011 char_class  input  2  selected class (0 none, 1 melee, 2 archer).
REQ-012 player_hp  input  4  current player HP.
REQ-013 boss_dead  input  1  boss defeated, level signal.
REQ-014 vblnk  input  1  vertical blank from the VGA timing chain.
REQ-015 pause_key  input  1  pause request level; used only with GAME_PAUSE_EN.
REQ-016 game_active  output  2  0 MENU, 1 PLAY, 2 LOSE, 3 WIN.
REQ-017 paused  output  1  play is frozen.
REQ-018 game_reset  output  1  one-cycle pulse that reinitialises player, boss and projectiles.
REQ-019 start_hover  output  1  cursor is inside the start region and char_class != 0.

Function
REQ-020 All outputs SHALL be registered; game_active SHALL change on the clk edge after the triggering condition is sampled.
REQ-021 A click SHALL be the mouse_left 0->1 edge, detected against a registered copy of mouse_left; a held button SHALL NOT retrigger.
REQ-022 A frame tick SHALL be the vblnk 0->1 edge.
REQ-023 The start region SHALL be inclusive of START_X/START_Y and exclusive of START_X+START_W/START_Y+START_H, compared with unsigned 12-bit values.
REQ-024 MENU->PLAY SHALL occur on a click inside the start region with char_class != 0; with char_class == 0 the click SHALL be ignored.
REQ-025 On entering PLAY, game_reset SHALL pulse high for exactly one cycle, coincident with game_active becoming 1.
REQ-026 PLAY->LOSE SHALL occur when player_hp == 0; PLAY->WIN SHALL occur when boss_dead == 1.
REQ-027 If player_hp == 0 and boss_dead == 1 in the same cycle, LOSE SHALL take priority.
REQ-028 On entering LOSE or WIN, a frame counter (8 bits minimum) SHALL load END_FRAMES and decrement once per frame tick.
REQ-029 LOSE or WIN SHALL return to MENU when the counter reaches 0 after a decrement, or earlier on any click.
REQ-030 If END_FRAMES == 0, the return to MENU SHALL occur on the first frame tick.
REQ-031 player_hp and boss_dead SHALL be ignored outside PLAY.
REQ-032 start_hover SHALL be 0 outside MENU.

Reset
REQ-033 Asserting rst at any time SHALL immediately force: game_active=0, paused=0, game_reset=0, start_hover=0, frame counter=0, edge-detect registers=0.
REQ-034 A click in flight at reset deassertion SHALL NOT be seen as an edge while mouse_left stays high.

Configuration
REQ-035 With macro GAME_PAUSE_EN defined, a pause_key 0->1 edge in PLAY SHALL toggle paused.
REQ-036 With GAME_PAUSE_EN defined, the PLAY->LOSE and PLAY->WIN transitions SHALL be suppressed while paused=1.
REQ-037 With GAME_PAUSE_EN defined, paused SHALL clear on any exit from PLAY.
REQ-038 Without GAME_PAUSE_EN, paused SHALL be constant 0 and pause_key SHALL be unused.

Verification
REQ-039 Reset then char_class=0, click at (500,310) -> game_active stays 0; set char_class=1, click again -> game_active=1 next cycle, game_reset high for exactly 1 cycle.
REQ-040 In PLAY, drive player_hp=0 and boss_dead=1 together -> game_active=2.
REQ-041 LOSE with END_FRAMES=3 and no clicks -> game_active=0 exactly on the 3rd vblnk rising edge.
REQ-042 Hold mouse_left high across the MENU->PLAY transition and through LOSE -> no early return to MENU until a release followed by a new press.
REQ-043 GAME_PAUSE_EN defined: pause_key edge in PLAY, then player_hp=0 -> paused=1 and game_active stays 1; second pause_key edge -> game_active=2.
REQ-044 Assert rst mid-WIN with the counter at 100 -> all outputs 0 immediately; a click inside the start region after reset with char_class=2 -> PLAY.
